// File: rtl/vga_scanout_fb.sv
// vga_scanout_fb
//   Receiving end of the pixel-plot interface. Holds a 320x240 RGB444
//   framebuffer, clears it after reset, accepts one pixel write per CLOCK_50
//   cycle and scans it out as 640x480@60 VGA with every stored pixel shown
//   as a 2x2 block.
//
//   Optional feature macro: FB_COLOUR_KEY_EN -- when defined, RUN-state plots
//   whose colour equals KEY_COLOUR are dropped (hardware sprite transparency).
//
// Ports
//   CLOCK_50     in   system clock, 50 MHz
//   reset        in   synchronous active-high reset
//   x, y         in   write column (0..319) / row (0..239)
//   colour       in   RGB444 write data {R,G,B}
//   plot         in   write strobe, one pixel per cycle
//   busy         out  high while the post-reset clear runs (plots ignored)
//   frame_start  out  one-cycle pulse when the scan counters sit at (0,0)
//   VGA_CLK      out  25 MHz pixel clock
//   VGA_HS/VS    out  syncs, active low
//   VGA_BLANK_N  out  low outside the visible area
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  8-bit channels, nibble replicated
module vga_scanout_fb #(
  parameter logic [11:0] CLEAR_COLOUR = 12'h000,
  parameter logic [11:0] KEY_COLOUR   = 12'hFFF,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [11:0] colour,
  input  logic        plot,
  output logic        busy,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int          FB_SIZE = 320 * 240;
  localparam logic [16:0] FB_LAST = 17'(FB_SIZE - 1);
  localparam logic [9:0]  H_VIS_L = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_L = 10'(V_VIS);
  localparam logic [9:0]  H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_SS    = 10'(H_VIS + H_FP);
  localparam logic [9:0]  H_SE    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_SS    = 10'(V_VIS + V_FP);
  localparam logic [9:0]  V_SE    = 10'(V_VIS + V_FP + V_SYNC - 1);

`ifdef FB_COLOUR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e      state_q;
  logic [16:0] clr_addr_q;
  logic        busy_q;
  logic        pix_en_q, vga_clk_q, fs_q;
  logic [9:0]  h_q, v_q, h_d, v_d;
  logic        vis1_q, hs1_q, vs1_q;           // stage 1 (aligned with RAM read)
  logic        hs_q, vs_q, blank_n_q;          // stage 2 (output registers)
  logic [7:0]  r_q, g_q, b_q;
  logic [11:0] rd_q;

  logic [11:0] fb_mem [FB_SIZE];

  // ---------------- write port ----------------
  logic        in_range, key_drop, we;
  logic [16:0] plot_addr, wr_addr;
  logic [11:0] wr_data;

  assign in_range  = (x < 9'd320) && (y < 8'd240);
  assign key_drop  = KEY_EN && (colour == KEY_COLOUR);
  // y*320 + x as shifts: 320 = 256 + 64
  assign plot_addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};

  always_comb begin
    we      = 1'b0;
    wr_addr = plot_addr;
    wr_data = colour;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        we      = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = CLEAR_COLOUR;
      end else if (plot && in_range && !key_drop) begin
        we = 1'b1;
      end
    end
  end

  // ---------------- read port ----------------
  logic        vis0;
  logic [8:0]  rd_row, rd_col;
  logic [16:0] rd_addr;

  assign vis0    = (h_q < H_VIS_L) && (v_q < V_VIS_L);
  assign rd_row  = v_q[9:1];
  assign rd_col  = h_q[9:1];
  // Only visible positions map into the framebuffer; park elsewhere at 0.
  assign rd_addr = vis0 ? ({rd_row, 8'b0} + {2'b0, rd_row, 6'b0} + {8'b0, rd_col}) : '0;

  // Write and read in one block: non-blocking update gives old data on a
  // same-address collision.
  always_ff @(posedge CLOCK_50) begin
    if (we) fb_mem[wr_addr] <= wr_data;
    if (pix_en_q) rd_q <= fb_mem[rd_addr];
  end

  // ---------------- scan counters ----------------
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // ---------------- control, timing and output pipeline ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
      pix_en_q   <= 1'b0;
      vga_clk_q  <= 1'b0;
      fs_q       <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      vis1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      vga_clk_q <= pix_en_q;        // registered complement of the next pix_en
      fs_q      <= pix_en_q && (h_q == '0) && (v_q == '0);

      if (pix_en_q) begin
        h_q       <= h_d;
        v_q       <= v_d;
        vis1_q    <= vis0;
        hs1_q     <= !((h_q >= H_SS) && (h_q <= H_SE));
        vs1_q     <= !((v_q >= V_SS) && (v_q <= V_SE));
        hs_q      <= hs1_q;
        vs_q      <= vs1_q;
        blank_n_q <= vis1_q;
        // The framebuffer holds garbage until the clear is done, so keep
        // the DAC dark while busy.
        if (vis1_q && !busy_q) begin
          r_q <= {rd_q[11:8], rd_q[11:8]};
          g_q <= {rd_q[7:4],  rd_q[7:4]};
          b_q <= {rd_q[3:0],  rd_q[3:0]};
        end else begin
          r_q <= '0;
          g_q <= '0;
          b_q <= '0;
        end
      end

      case (state_q)
        S_CLEAR: begin
          if (clr_addr_q == FB_LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 17'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign frame_start = fs_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scanout_fb.sv
// Bench for vga_scanout_fb. A reduced raster (40x20 ticks) keeps frames
// short; the framebuffer and clear length are full size. Expected scanout is
// derived from the cycle count since reset: after edge n the outputs show
// raster position n/2-2.
module tb_vga_scanout_fb;
  localparam int HV = 32, HFP = 2, HSY = 4, HBP = 2, HT = HV + HFP + HSY + HBP;
  localparam int VV = 16, VFP = 1, VSY = 2, VBP = 1, VT = VV + VFP + VSY + VBP;
  localparam int FT = HT * VT;                 // pixel ticks per frame
  localparam int FB_N = 76800;
  localparam logic [11:0] CLR = 12'h3A7;
  localparam logic [11:0] KEY = 12'hFFF;
`ifdef FB_COLOUR_KEY_EN
  localparam bit KEYED = 1'b1;
`else
  localparam bit KEYED = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, plot = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [11:0] colour = '0;
  logic        busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int checks = 0, passed = 0;
  int unsigned ncyc;
  logic [11:0] fbm [FB_N];

  vga_scanout_fb #(
    .CLEAR_COLOUR(CLR), .KEY_COLOUR(KEY),
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .frame_start(frame_start), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  // ---------------- reference model ----------------
  function automatic int pos_of(int unsigned n);
    return int'((n / 2 + FT - 2) % FT);
  endfunction

  // {hs, vs, blank_n, frame_start, vga_clk} expected after edge n (n >= 4)
  function automatic logic [4:0] m_ctl(int unsigned n);
    int p = pos_of(n);
    int h = p % HT, v = p / HT;
    logic hs  = !(h >= HV + HFP && h < HV + HFP + HSY);
    logic vs  = !(v >= VV + VFP && v < VV + VFP + VSY);
    logic vis = (h < HV) && (v < VV);
    logic fs  = (n % 2 == 0) && ((n / 2 - 1) % FT == 0);
    logic vck = (n % 2 == 0);
    return {hs, vs, vis, fs, vck};
  endfunction

  function automatic logic [23:0] m_rgb(int unsigned n);
    int p = pos_of(n);
    int h = p % HT, v = p / HT;
    logic [11:0] c;
    if (!(h < HV && v < VV)) return 24'h0;
    c = fbm[(v / 2) * 320 + h / 2];
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_plot(int px, int py, logic [11:0] pc, bit pl);
    x = 9'(px); y = 8'(py); colour = pc; plot = pl;
    step();
    if (pl && ncyc >= 76801 && px < 320 && py < 240 && !(KEYED && pc == KEY))
      fbm[py * 320 + px] = pc;
  endtask

  // advance until the outputs show screen position (sh, sv)
  task automatic goto_px(int sh, int sv);
    int unsigned nt = 2 * (sv * HT + sh + 2);
    while (nt <= ncyc + 4) nt += 2 * FT;
    repeat (nt - ncyc) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N} !== 7'b1001100)
      $display("FAIL reset_ctl: got %b want 1001100",
               {busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N});
    else passed++;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0)
      $display("FAIL reset_rgb: got %h want 000000", {VGA_R, VGA_G, VGA_B});
    else passed++;
    reset = 1'b0;
    step(); step();
    checks++;
    if ({frame_start, VGA_CLK} !== 2'b11)
      $display("FAIL first_frame_start: got %b want 11", {frame_start, VGA_CLK});
    else passed++;
    step();
    checks++;
    if ({frame_start, VGA_CLK} !== 2'b00)
      $display("FAIL frame_start_width: got %b want 00", {frame_start, VGA_CLK});
    else passed++;
  endtask

  task automatic test_clear();
    int bad = 0;
    goto_px(35, 17);                            // inside both sync pulses
    checks++;
    if ({VGA_HS, VGA_VS, busy} !== 3'b001)
      $display("FAIL pre_reset_sync: got %b want 001", {VGA_HS, VGA_VS, busy});
    else passed++;
    reset = 1'b1;
    step();
    checks++;
    if ({busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N} !== 6'b100110)
      $display("FAIL midclear_reset: got %b want 100110",
               {busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N});
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 80000 && busy === 1'b1; i++) begin
      if (i == 0) begin x = 9'd7; y = 8'd2; colour = 12'h00F; plot = 1'b1; end
      if (i == 50) plot = 1'b0;
      step();
      if (busy === 1'b1 && {VGA_R, VGA_G, VGA_B} !== 24'h0) bad++;
      if (ncyc >= 4 && {VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK} !== m_ctl(ncyc)) bad++;
    end
    checks++;
    if (ncyc !== 76800 || busy !== 1'b0)
      $display("FAIL clear_length: busy=%b at cycle %0d, want 0 at 76800", busy, ncyc);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL clear_scanout: %0d bad cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_timing();
    int last_hf = -1, line_per = -1, hs_run = 0, hs_w = -1, vs_run = 0, vs_w = -1;
    int last_fs = -1, fs_per = -1, lines = 0, lpf = -1, fs_run = 0, fs_w = -1, bad = 0;
    logic phs, pfs;
    step(); step();
    phs = VGA_HS; pfs = frame_start;
    for (int i = 0; i < 4 * FT + 8; i++) begin
      step();
      if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK} !== m_ctl(ncyc) ||
          {VGA_R, VGA_G, VGA_B} !== m_rgb(ncyc)) bad++;
      if (phs && !VGA_HS) begin
        if (last_hf >= 0) line_per = i - last_hf;
        last_hf = i;
        lines++;
      end
      if (!VGA_HS) hs_run++; else if (hs_run > 0) begin hs_w = hs_run; hs_run = 0; end
      if (!VGA_VS) vs_run++; else if (vs_run > 0) begin vs_w = vs_run; vs_run = 0; end
      if (frame_start) fs_run++; else if (fs_run > 0) begin fs_w = fs_run; fs_run = 0; end
      if (!pfs && frame_start) begin
        if (last_fs >= 0) begin fs_per = i - last_fs; lpf = lines; end
        last_fs = i;
        lines = 0;
      end
      phs = VGA_HS; pfs = frame_start;
    end
    checks++;
    if (line_per !== 2 * HT) $display("FAIL line_period: got %0d want %0d", line_per, 2 * HT);
    else passed++;
    checks++;
    if (hs_w !== 2 * HSY) $display("FAIL hs_width: got %0d want %0d", hs_w, 2 * HSY);
    else passed++;
    checks++;
    if (vs_w !== 2 * HT * VSY) $display("FAIL vs_width: got %0d want %0d", vs_w, 2 * HT * VSY);
    else passed++;
    checks++;
    if (fs_per !== 2 * FT) $display("FAIL frame_period: got %0d want %0d", fs_per, 2 * FT);
    else passed++;
    checks++;
    if (lpf !== VT) $display("FAIL lines_per_frame: got %0d want %0d", lpf, VT);
    else passed++;
    checks++;
    if (fs_w !== 1) $display("FAIL frame_start_pulse: got %0d want 1", fs_w);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL cleared_frame: %0d bad cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_plot();
    int          sh[8] = '{10, 9, 10, 11, 12, 10, 11, 11};
    int          sv[8] = '{5, 6, 6, 6, 6, 7, 7, 8};
    logic [23:0] ex[8] = '{24'h33AA77, 24'h33AA77, 24'hAA55CC, 24'hAA55CC,
                           24'h33AA77, 24'hAA55CC, 24'hAA55CC, 24'h33AA77};
    do_plot(5, 3, 12'hA5C, 1'b1);
    plot = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto_px(sh[k], sv[k]);
      checks++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, ex[k]})
        $display("FAIL plot_px(%0d,%0d): got %b/%h want 1/%h",
                 sh[k], sv[k], VGA_BLANK_N, {VGA_R, VGA_G, VGA_B}, ex[k]);
      else passed++;
    end
  endtask

  task automatic test_out_of_range();
    int sh[4] = '{0, 14, 30, 0};
    int sv[4] = '{2, 4, 4, 6};
    do_plot(320, 0, 12'h0F0, 1'b1);
    do_plot(0, 240, 12'h0F0, 1'b1);
    do_plot(320, 2, 12'h0F0, 1'b1);
    do_plot(335, 1, 12'h0F0, 1'b1);
    plot = 1'b0;
    for (int k = 0; k < 4; k++) begin
      goto_px(sh[k], sv[k]);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== 24'h33AA77)
        $display("FAIL dropped_px(%0d,%0d): got %h want 33aa77", sh[k], sv[k], {VGA_R, VGA_G, VGA_B});
      else passed++;
    end
  endtask

  task automatic test_colour_key();
    logic [23:0] exp_c = KEYED ? 24'h00FF00 : 24'hFFFFFF;
    do_plot(1, 1, 12'h0F0, 1'b1);
    do_plot(1, 1, KEY, 1'b1);
    plot = 1'b0;
    goto_px(2, 2);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== exp_c)
      $display("FAIL key_px(2,2): got %h want %h", {VGA_R, VGA_G, VGA_B}, exp_c);
    else passed++;
    goto_px(3, 3);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== exp_c)
      $display("FAIL key_px(3,3): got %h want %h", {VGA_R, VGA_G, VGA_B}, exp_c);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bad = 0, first_n = -1;
    for (int i = 0; i < 200; i++) begin
      int px = int'($urandom_range(0, 15));
      int py = int'($urandom_range(0, 7));
      logic [11:0] pc = 12'($urandom);
      if ($urandom_range(0, 7) == 0) px = int'($urandom_range(320, 511));
      if ($urandom_range(0, 7) == 0) py = int'($urandom_range(240, 255));
      if ($urandom_range(0, 7) == 0) pc = KEY;
      do_plot(px, py, pc, $urandom_range(0, 3) != 0);
    end
    plot = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK} !== m_ctl(ncyc) ||
          {VGA_R, VGA_G, VGA_B} !== m_rgb(ncyc)) begin
        if (first_n < 0) first_n = int'(ncyc);
        bad++;
      end
    end
    checks++;
    if (bad !== 0) $display("FAIL random_frame: %0d bad cycles (first at %0d), want 0", bad, first_n);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < FB_N; i++) fbm[i] = CLR;
    test_reset();
    test_clear();
    test_timing();
    test_plot();
    test_out_of_range();
    test_colour_key();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
